uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Generates its own oversampling tick from CLK_FREQ/BAUD_RATE. Supports configurable data width, parity and stop-bit count, uses majority-vote mid-bit sampling, and reports framing and parity errors. Sits between the board RX pin and byte-level consumers such as the LED command decoder.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate
OVERSAMPLE, 16, ticks per bit; even, >=8
DATA_BITS, 8, payload bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  receiver enable; low holds the FSM in IDLE and clears the tick divider
rx  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  received payload, LSB = first bit on the line
valid_out  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity mismatch, qualified by valid_out
frame_err  output  1  stop bit sampled low, qualified by valid_out
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE, all counters 0, data_out=0, valid_out=0, parity_err=0, frame_err=0, busy=0. Synchroniser flops are set to 1.
- Input conditioning: rx passes through a 2-FF synchroniser into rx_s. Edge detection uses a third flop.
- Tick divider:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated.
  - Counter runs 0..DIV-1 while en=1 and emits tick for one clk at DIV-1.
  - Counter is cleared on en=0 and re-phased to 0 on start-edge detection in IDLE.
  - DIV<2 is illegal (elaboration $error).
- Sample counter os_cnt counts ticks 0..OVERSAMPLE-1 within each bit.
- Bit decision is a majority of rx_s captured at ticks M-1, M and M+1, where M = OVERSAMPLE/2.
- FSM states and transitions:
  - IDLE: on a falling edge of rx_s with en=1 -> START, os_cnt=0.
  - START: at tick M-1 (vote complete at M+1), a voted 1 is a false start -> IDLE with no output. A voted 0 -> on the os_cnt wrap -> DATA, bit_cnt=0.
  - DATA: at each vote, shift the bit into the shift register (LSB first). After DATA_BITS bits -> PARITY if PARITY!=0, else STOP.
  - PARITY: compare the voted bit against XOR(data) (even) or ~XOR(data) (odd). A mismatch sets the internal perr.
  - STOP: each stop bit is voted; any 0 sets the internal ferr. Immediately after the vote of the final stop bit -> IDLE, without waiting for the bit end, so back-to-back frames are accepted.
- Output timing:
  - valid_out pulses 1 clk after the final stop-bit vote.
  - data_out, parity_err and frame_err update on the same cycle and hold until the next frame.
  - Data is delivered even when errors are flagged.
- busy = (state != IDLE).
- en dropped mid-frame: FSM -> IDLE on the next clk, no valid_out, and outputs keep their previous values.
- rst mid-frame: immediate return to reset values, no partial output.
- Parity bit is ignored in the computation when PARITY=0. Frame length = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits.

Optional Feature:
Macro UART_RX_BREAK_DETECT_EN.
- Defined: adds output break_det (1 bit, reset 0).
  - When rx_s is low for a full frame (data bits all 0, parity ignored, first stop bit 0), pulse break_det with valid_out and suppress frame_err for that frame.
  - After such a frame, the FSM waits in IDLE for rx_s=1 before re-arming start detection.
- Undefined: no break_det port; such a frame reports data_out=0 and frame_err=1.

Test Plan:
- 8N1 defaults (DIV=13), loopback from the existing uart_tx, sends 0xAA then 0x5C -> two valid_out pulses with data_out=0xAA then 0x5C, both errors 0.
- PARITY=2, DATA_BITS=7, STOP_BITS=2, bench drives 0x41 with the correct parity bit, then 0x41 with an inverted parity bit -> first frame parity_err=0, second frame parity_err=1 with data_out=0x41.
- Stop bit driven low on a 0x3C frame -> valid_out with data_out=0x3C and frame_err=1.
- Glitch: rx low for 4 ticks then high -> no valid_out, busy returns to 0 within 1 bit time. A single-tick low spike inside a data bit is out-voted and the byte is received correctly.
- en deasserted mid-frame, then re-enabled and 0x12 sent -> no output for the aborted frame, then 0x12 received cleanly. rst pulsed mid-frame -> all outputs return to 0 asynchronously.
- With UART_RX_BREAK_DETECT_EN: rx held low for 2 frame times -> exactly one break_det pulse, frame_err=0, no further valid_out until rx returns high and a new frame 0x01 is received.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: oversampled, majority-voted, with parity/stop checking.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_cfg #(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   output logic                 parity_err,
   output logic                 frame_err,
`ifdef UART_RX_BREAK_DETECT_EN
   output logic                 break_det,
`endif
   output logic                 busy
);
   localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int M   = OVERSAMPLE / 2;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);

   if (DIV < 2) begin : g_div_chk
      $error("uart_rx_cfg: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state;
   logic                 s1, rx_s, rx_d;
   logic [DW-1:0]        div_cnt;
   logic [OW-1:0]        os_cnt;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           smp;
   logic                 perr, ferr;
   logic                 fall, tick, vote, par_exp, last_stop, arm;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         s1   <= rx;
         rx_s <= s1;
         rx_d <= rx_s;
      end
   end

   assign fall      = rx_d & ~rx_s;
   assign tick      = en && (div_cnt == DW'(DIV - 1));
   // third sample is the live rx_s at tick M+1
   assign vote      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
   assign par_exp   = (PARITY == 2) ? ^shreg : ~^shreg;
   assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
   assign busy      = (state != IDLE);

`ifdef UART_RX_BREAK_DETECT_EN
   logic brk_r, brk_now, wait_hi;
   assign brk_now = stop_cnt ? brk_r : ((shreg == '0) && !vote);
   assign arm     = ~wait_hi;
`else
   assign arm = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         os_cnt     <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shreg      <= '0;
         smp        <= '0;
         perr       <= 1'b0;
         ferr       <= 1'b0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         break_det  <= 1'b0;
         brk_r      <= 1'b0;
         wait_hi    <= 1'b0;
`endif
      end else begin
         valid_out <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         break_det <= 1'b0;
`endif
         if (!en) begin
            state   <= IDLE;
            div_cnt <= '0;
            os_cnt  <= '0;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (state == IDLE) begin
               os_cnt <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
               if (wait_hi && rx_s) wait_hi <= 1'b0;
`endif
               if (fall && arm) begin
                  state    <= START;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  stop_cnt <= 1'b0;
                  perr     <= 1'b0;
                  ferr     <= 1'b0;
               end
            end else if (tick) begin
               os_cnt <= (os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt + OW'(1);
               if (os_cnt == OW'(M - 1)) smp[0] <= rx_s;
               if (os_cnt == OW'(M))     smp[1] <= rx_s;
               if (os_cnt == OW'(M + 1)) begin
                  case (state)
                     START: if (vote) state <= IDLE;
                     DATA:  shreg <= {vote, shreg[DATA_BITS-1:1]};
                     PAR:   if (vote != par_exp) perr <= 1'b1;
                     STOP: begin
                        // leave at the last stop vote so a back-to-back start edge is seen
                        if (last_stop) begin
                           state      <= IDLE;
                           valid_out  <= 1'b1;
                           data_out   <= shreg;
                           parity_err <= perr;
                           frame_err  <= ferr | ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
                           if (brk_now) begin
                              break_det <= 1'b1;
                              frame_err <= 1'b0;
                              wait_hi   <= 1'b1;
                           end
`endif
                        end else begin
                           ferr <= ferr | ~vote;
                        end
`ifdef UART_RX_BREAK_DETECT_EN
                        if (!stop_cnt) brk_r <= (shreg == '0) && !vote;
`endif
                     end
                     default: ;
                  endcase
               end
               if (os_cnt == OW'(OVERSAMPLE - 1)) begin
                  case (state)
                     START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                     end
                     DATA: begin
                        if (bit_cnt == BW'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
                        else bit_cnt <= bit_cnt + BW'(1);
                     end
                     PAR:  state <= STOP;
                     STOP: stop_cnt <= 1'b1;
                     default: ;
                  endcase
               end
            end
         end
      end
   end
endmodule
